// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    HDR_LO = 3'd0,
    HDR_HI = 3'd1,
    DATA   = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } loader_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream into 32-bit little-endian words.
// The first byte pushed lands in word[7:0]. word_valid pulses combinationally
// alongside the 4th push so the caller can register the completed word on
// that same edge.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  cnt_r;
  logic [31:0] shreg_r;

  // Byte counter and right-shifting assembly register; a stall keeps the partial word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= 2'd0;
      shreg_r <= 32'd0;
    end else if (clear) begin
      cnt_r   <= 2'd0;
      shreg_r <= 32'd0;
    end else if (push) begin
      cnt_r   <= cnt_r + 2'd1;
      shreg_r <= {in_data, shreg_r[31:8]};
    end
  end

  // Completed word is the incoming byte on top of the three already held
  always_comb begin
    word       = {in_data, shreg_r[31:8]};
    word_valid = push && (cnt_r == LAST_IDX);
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: receives a header-prefixed byte image,
// writes it word by word into imem, then releases the CPU reset.
module imem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

  loader_state_t state_r, state_nxt;

  logic [15:0] n_r;
  logic [15:0] hdr_full_s;
  logic        accept_s;
  logic        reload_ok_s;
  logic        push_s;
  logic        last_word_s;
  logic [31:0] word_s;
  logic        word_valid_s;

  // Handshake and control decode from the current state
  always_comb begin
    in_ready    = (state_r == HDR_LO) || (state_r == HDR_HI) || (state_r == DATA);
    accept_s    = in_valid && in_ready;
    push_s      = accept_s && (state_r == DATA);
    reload_ok_s = reload && ((state_r == DONE) || (state_r == ERR));
    hdr_full_s  = {in_data, n_r[7:0]};
    last_word_s = ((16'(words_loaded) + 16'd1) == n_r);
  end

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (reload_ok_s),
    .push       (push_s),
    .in_data    (in_data),
    .word       (word_s),
    .word_valid (word_valid_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= HDR_LO;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic: header parse, payload, terminal states with reload
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      HDR_LO: begin
        if (accept_s) begin
          state_nxt = HDR_HI;
        end else begin
          state_nxt = HDR_LO;
        end
      end
      HDR_HI: begin
        if (accept_s) begin
          if (hdr_full_s == 16'd0) begin
            state_nxt = DONE;
          end else if ({1'b0, hdr_full_s} > DEPTH_L) begin
            state_nxt = ERR;
          end else begin
            state_nxt = DATA;
          end
        end else begin
          state_nxt = HDR_HI;
        end
      end
      DATA: begin
        if (word_valid_s && last_word_s) begin
          state_nxt = DONE;
        end else begin
          state_nxt = DATA;
        end
      end
      DONE, ERR: begin
        if (reload_ok_s) begin
          state_nxt = HDR_LO;
        end else begin
          state_nxt = state_r;
        end
      end
      default: begin
        state_nxt = HDR_LO;
      end
    endcase
  end

  // Header capture, write strobe, word index and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_r          <= 16'd0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      if (reload_ok_s) begin
        n_r          <= 16'd0;
        words_loaded <= '0;
        done         <= 1'b0;
        error        <= 1'b0;
        cpu_rst      <= 1'b1;
      end else begin
        done    <= (state_r == DONE);
        error   <= (state_r == ERR);
        cpu_rst <= (state_r != DONE);
        if (accept_s && (state_r == HDR_LO)) begin
          n_r[7:0] <= in_data;
        end
        if (accept_s && (state_r == HDR_HI)) begin
          n_r[15:8] <= in_data;
        end
        if (word_valid_s) begin
          imem_we      <= 1'b1;
          imem_addr    <= words_loaded[ADDR_W-1:0];
          imem_wdata   <= word_s;
          words_loaded <= words_loaded + 1'b1;
        end
      end
    end
  end

endmodule
